// File: rtl/sig_dump_pkg.sv
// Register map, STATUS bit positions and controller states shared by the
// signature dump controller, its FIFO and the bench.
package sig_dump_pkg;

  localparam logic [9:0] OFF_BEGIN  = 10'h000;
  localparam logic [9:0] OFF_END    = 10'h004;
  localparam logic [9:0] OFF_CTRL   = 10'h008;
  localparam logic [9:0] OFF_STATUS = 10'h00C;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_ERR
  } sig_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sig_dump_ctrl_if.sv
// Register bus, host read master and signature stream of the dump controller.
// slave is the controller's view, master the environment's.
interface sig_dump_ctrl_if;
  logic        dev_req_i;
  logic        dev_we_i;
  logic [31:0] dev_addr_i;
  logic [31:0] dev_wdata_i;
  logic [3:0]  dev_be_i;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dev_err_o;

  logic        host_req_o;
  logic [31:0] host_addr_o;
  logic        host_gnt_i;
  logic        host_rvalid_i;
  logic [31:0] host_rdata_i;
  logic        host_err_i;

  logic        sig_valid_o;
  logic        sig_ready_i;
  logic [31:0] sig_data_o;
  logic        sig_last_o;

  modport slave (
    input  dev_req_i, dev_we_i, dev_addr_i, dev_wdata_i, dev_be_i,
    output dev_rvalid_o, dev_rdata_o, dev_err_o,
    output host_req_o, host_addr_o,
    input  host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
    output sig_valid_o, sig_data_o, sig_last_o,
    input  sig_ready_i
  );

  modport master (
    output dev_req_i, dev_we_i, dev_addr_i, dev_wdata_i, dev_be_i,
    input  dev_rvalid_o, dev_rdata_o, dev_err_o,
    input  host_req_o, host_addr_o,
    output host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
    input  sig_valid_o, sig_data_o, sig_last_o,
    output sig_ready_i
  );
endinterface

// File: rtl/sig_dump_fifo.sv
// Purpose: count-based synchronous FIFO with flush, head word visible while non-empty.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push refused only when full and not popping in the same cycle.
module sig_dump_fifo #(
  parameter int Depth = 4,
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(Depth));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sig_dump_ctrl.sv
// Purpose: reads memory from SIG_BEGIN up to SIG_END and streams the words out as a signature.
// Latency: register response 1 cycle; host rvalid to sig_valid_o 1 cycle.
// Backpressure: sig_ready_i low fills the FIFO, after which no further host reads are issued.
module sig_dump_ctrl
  import sig_dump_pkg::*;
#(
  parameter int FifoDepth = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sig_dump_ctrl_if.slave bus,
  output logic           done_o,
  output logic           err_o
);
  sig_state_e  state_q;
  logic [31:0] begin_q, end_q, ptr_q, ptr_nxt;
  logic        dev_rvalid_q, dev_err_q;
  logic [31:0] dev_rdata_q, status_w;
  logic [9:0]  off;
  logic        busy, start_wr, rsp_ok, rsp_bad;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [32:0] fifo_out;
  logic        unused_addr_hi;

  assign off            = bus.dev_addr_i[9:0];
  assign unused_addr_hi = ^bus.dev_addr_i[31:10];
  assign busy     = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign start_wr = bus.dev_req_i && bus.dev_we_i && (off == OFF_CTRL) && bus.dev_wdata_i[0];
  assign rsp_ok   = (state_q == S_WAIT) && bus.host_rvalid_i && !bus.host_err_i;
  assign rsp_bad  = (state_q == S_WAIT) && bus.host_rvalid_i && bus.host_err_i;
  assign ptr_nxt  = ptr_q + 32'd4;
  assign done_o   = (state_q == S_DONE);
  assign err_o    = (state_q == S_ERR);

  // A request is only raised with a slot reserved for its data; nothing else
  // can fill the FIFO while it waits for the grant, so req stays stable.
  assign bus.host_req_o  = (state_q == S_REQ) && !fifo_full;
  assign bus.host_addr_o = ptr_q;

  assign bus.sig_valid_o = !fifo_empty;
  assign bus.sig_data_o  = fifo_empty ? '0 : fifo_out[31:0];
  assign bus.sig_last_o  = !fifo_empty && fifo_out[32];
  assign fifo_pop        = bus.sig_valid_o && bus.sig_ready_i;

  assign bus.dev_rvalid_o = dev_rvalid_q;
  assign bus.dev_rdata_o  = dev_rdata_q;
  assign bus.dev_err_o    = dev_err_q;

  always_comb begin
    status_w            = '0;
    status_w[STAT_BUSY] = busy;
    status_w[STAT_DONE] = done_o;
    status_w[STAT_ERR]  = err_o;
  end

  sig_dump_fifo #(.Depth(FifoDepth), .Width(33)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (rsp_bad),
    .push_i      (rsp_ok),
    .push_data_i ({ptr_nxt == end_q, bus.host_rdata_i}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
      dev_err_q    <= 1'b0;
      begin_q      <= '0;
      end_q        <= '0;
    end else begin
      dev_rvalid_q <= bus.dev_req_i;
      dev_rdata_q  <= '0;
      dev_err_q    <= 1'b0;
      if (bus.dev_req_i && bus.dev_we_i) begin
        case (off)
          OFF_BEGIN: if (busy) dev_err_q <= 1'b1;
                     else begin_q <= be_merge(begin_q, bus.dev_wdata_i, bus.dev_be_i);
          OFF_END:   if (busy) dev_err_q <= 1'b1;
                     else end_q <= be_merge(end_q, bus.dev_wdata_i, bus.dev_be_i);
          OFF_CTRL:  ;
          default:   dev_err_q <= 1'b1;
        endcase
      end else if (bus.dev_req_i) begin
        case (off)
          OFF_BEGIN:  dev_rdata_q <= begin_q;
          OFF_END:    dev_rdata_q <= end_q;
          OFF_CTRL:   dev_rdata_q <= '0;
          OFF_STATUS: dev_rdata_q <= status_w;
          default:    dev_err_q   <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_wr) begin
            if ((begin_q[1:0] != 2'b00) || (end_q[1:0] != 2'b00) || (begin_q > end_q)) begin
              state_q <= S_ERR;
            end else if (begin_q == end_q) begin
              state_q <= S_DONE;
            end else begin
              ptr_q   <= begin_q;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ:   if (bus.host_req_o && bus.host_gnt_i) state_q <= S_WAIT;
        S_WAIT: begin
          if (rsp_bad) begin
            state_q <= S_ERR;
          end else if (rsp_ok) begin
            ptr_q   <= ptr_nxt;
            state_q <= (ptr_nxt == end_q) ? S_DRAIN : S_REQ;
          end
        end
        S_DRAIN: if (fifo_empty) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Directed and randomized dumps against a memory/stream reference model:
// expected stream is simply mem[BEGIN..END-4] in address order, last on the final word.
module tb_sig_dump_ctrl;
  import sig_dump_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic done_o, err_o;
  int   errors = 0;
  int   checks = 0;

  sig_dump_ctrl_if bus ();

  sig_dump_ctrl #(.FifoDepth(4)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus.slave),
    .done_o (done_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Environment knobs (written only by the stimulus block).
  logic [31:0] seed;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
  int rv_lat     = -1;  // fixed rvalid latency when >= 0
  int err_at     = -1;  // absolute read index that returns host_err_i

  // Observations (written only by the responder / sink processes).
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          gnt_wait = 0, rv_wait = 0, rd_idx = 0;
  logic [31:0] host_log[$];
  logic [31:0] got_dat[$];
  logic        got_last[$];
  int          req_cycles = 0, valid_cycles = 0;
  int          outst_viol = 0, hold_viol = 0, stab_viol = 0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_a = '0, prev_d = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return ((a - 32'h100) >> 2) + 32'd1;
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // Host memory: random grant delay, random or fixed read latency, one-shot error.
  always @(negedge clk_i) begin
    if (bus.host_req_o) req_cycles++;
    if (pend && bus.host_req_o) outst_viol++;
    if (!rst_i && prev_req && !prev_gnt && (!bus.host_req_o || bus.host_addr_o !== prev_a))
      hold_viol++;
    bus.host_gnt_i    = 1'b0;
    bus.host_rvalid_i = 1'b0;
    bus.host_err_i    = 1'b0;
    bus.host_rdata_i  = '0;
    if (pend) begin
      if (rv_wait == 0) begin
        bus.host_rvalid_i = 1'b1;
        bus.host_rdata_i  = mem_word(pend_addr);
        bus.host_err_i    = (rd_idx == err_at);
        rd_idx++;
        pend = 1'b0;
      end else begin
        rv_wait--;
      end
    end else if (bus.host_req_o) begin
      if (gnt_wait == 0) begin
        bus.host_gnt_i = 1'b1;
        pend      = 1'b1;
        pend_addr = bus.host_addr_o;
        host_log.push_back(bus.host_addr_o);
        rv_wait   = (rv_lat >= 0) ? rv_lat : int'($urandom_range(0, 3));
        gnt_wait  = int'($urandom_range(0, 2));
      end else begin
        gnt_wait--;
      end
    end
    prev_req = bus.host_req_o;
    prev_gnt = bus.host_gnt_i;
    prev_a   = bus.host_addr_o;
  end

  // Stream sink: records every word that will handshake on the next rising edge.
  always @(negedge clk_i) begin : sink
    logic r;
    case (ready_mode)
      0:       r = 1'b1;
      1:       r = ($urandom_range(0, 2) != 0);
      default: r = 1'b0;
    endcase
    if (!rst_i && !err_o && prev_v && !prev_r &&
        (!bus.sig_valid_o || bus.sig_data_o !== prev_d))
      stab_viol++;
    bus.sig_ready_i = r;
    if (bus.sig_valid_o) valid_cycles++;
    if (bus.sig_valid_o && r) begin
      got_dat.push_back(bus.sig_data_o);
      got_last.push_back(bus.sig_last_o);
    end
    prev_v = bus.sig_valid_o;
    prev_r = r;
    prev_d = bus.sig_data_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dev_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err);
    @(negedge clk_i);
    bus.dev_req_i   = 1'b1;
    bus.dev_we_i    = we;
    bus.dev_addr_i  = addr;
    bus.dev_wdata_i = wdata;
    bus.dev_be_i    = be;
    @(negedge clk_i);
    bus.dev_req_i = 1'b0;
    bus.dev_we_i  = 1'b0;
    chk("dev_rvalid", 32'(bus.dev_rvalid_o), 32'd1);
    rdata = bus.dev_rdata_o;
    err   = bus.dev_err_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                    output logic err);
    logic [31:0] d;
    dev_op(1'b1, addr, data, be, d, err);
    chk("wr_rdata_zero", d, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic err);
    dev_op(1'b0, addr, 32'd0, 4'h0, d, err);
  endtask

  task automatic set_range(input logic [31:0] b, input logic [31:0] e);
    logic er;
    wr(32'h0, b, 4'hF, er);
    chk("wr_begin_err", 32'(er), 32'd0);
    wr(32'h4, e, 4'hF, er);
    chk("wr_end_err", 32'(er), 32'd0);
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    while (!(done_o || err_o) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_finished"}, 32'(done_o || err_o), 32'd1);
  endtask

  task automatic check_stream(input logic [31:0] b, input int nw, input int lb, input int gb,
                              input string tag);
    chk({tag, "_nwords"}, 32'(got_dat.size() - gb), 32'(nw));
    chk({tag, "_nreads"}, 32'(host_log.size() - lb), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      if (gb + i < got_dat.size()) begin
        chk({tag, "_data"}, got_dat[gb+i], mem_word(b + 32'(4*i)));
        chk({tag, "_last"}, 32'(got_last[gb+i]), 32'(i == nw - 1));
      end
      if (lb + i < host_log.size())
        chk({tag, "_addr"}, host_log[lb+i], b + 32'(4*i));
    end
  endtask

  task automatic run_ok(input logic [31:0] b, input int nw, input string tag);
    int lb, gb;
    logic [31:0] d;
    logic er;
    set_range(b, b + 32'(4*nw));
    lb = host_log.size();
    gb = got_dat.size();
    wr(32'h8, 32'h1, 4'hF, er);
    wait_end(3000, tag);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    check_stream(b, nw, lb, gb, tag);
    rd(32'hC, d, er);
    chk({tag, "_status"}, d, 32'h2);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic er;
    int lb, gb, rc, vc, n, nw;
    logic [31:0] b;

    seed = $urandom;
    bus.dev_req_i = 1'b0; bus.dev_we_i = 1'b0; bus.dev_addr_i = '0;
    bus.dev_wdata_i = '0; bus.dev_be_i = '0;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_dev_rvalid", 32'(bus.dev_rvalid_o), 32'd0);
    chk("rst_dev_err", 32'(bus.dev_err_o), 32'd0);
    chk("rst_host_req", 32'(bus.host_req_o), 32'd0);
    chk("rst_host_addr", bus.host_addr_o, 32'd0);
    chk("rst_sig_valid", 32'(bus.sig_valid_o), 32'd0);
    chk("rst_sig_data", bus.sig_data_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    rd(32'h0, d, er); chk("rst_begin", d, 32'd0);
    rd(32'hC, d, er); chk("rst_status", d, 32'd0);

    // Basic four-word dump with minimum latency.
    rv_lat = 0; ready_mode = 0;
    run_ok(32'h100, 4, "basic");

    // Stalled stream: only FifoDepth words may be fetched.
    set_range(32'h100, 32'h120);
    lb = host_log.size(); gb = got_dat.size();
    ready_mode = 2; rv_lat = -1;
    wr(32'h8, 32'h1, 4'hF, er);
    repeat (20) @(negedge clk_i);
    chk("stall_reads", 32'(host_log.size() - lb), 32'd4);
    chk("stall_req_low", 32'(bus.host_req_o), 32'd0);
    chk("stall_valid", 32'(bus.sig_valid_o), 32'd1);
    chk("stall_head", bus.sig_data_o, 32'd1);
    ready_mode = 0;
    wait_end(2000, "stall");
    check_stream(32'h100, 8, lb, gb, "stall");

    // Empty range completes at once with no traffic.
    set_range(32'h200, 32'h200);
    rc = req_cycles; vc = valid_cycles;
    wr(32'h8, 32'h1, 4'hF, er);
    chk("empty_done", 32'(done_o), 32'd1);
    repeat (5) @(negedge clk_i);
    chk("empty_no_req", 32'(req_cycles - rc), 32'd0);
    chk("empty_no_valid", 32'(valid_cycles - vc), 32'd0);

    // Misaligned and reversed ranges.
    lb = host_log.size(); rc = req_cycles;
    set_range(32'h102, 32'h110);
    wr(32'h8, 32'h1, 4'hF, er);
    chk("misal_err", 32'(err_o), 32'd1);
    chk("misal_done_cleared", 32'(done_o), 32'd0);
    rd(32'hC, d, er); chk("misal_status", d, 32'h4);
    set_range(32'h120, 32'h110);
    wr(32'h8, 32'h1, 4'hF, er);
    chk("rev_err", 32'(err_o), 32'd1);
    repeat (3) @(negedge clk_i);
    chk("bad_range_no_req", 32'(req_cycles - rc), 32'd0);

    // Byte enables on BEGIN/END.
    wr(32'h0, 32'hAABB_CCDD, 4'b0101, er);
    rd(32'h0, d, er); chk("be_begin", d, 32'h00BB_01DD);
    wr(32'h4, 32'h1234_5678, 4'b1000, er);
    rd(32'h4, d, er); chk("be_end", d, 32'h1200_0110);

    // Host error on the second read.
    set_range(32'h300, 32'h320);
    lb = host_log.size(); gb = got_dat.size();
    err_at = rd_idx + 1; ready_mode = 2;
    wr(32'h8, 32'h1, 4'hF, er);
    wait_end(500, "herr");
    chk("herr_err", 32'(err_o), 32'd1);
    chk("herr_done", 32'(done_o), 32'd0);
    chk("herr_flushed", 32'(bus.sig_valid_o), 32'd0);
    chk("herr_reads", 32'(host_log.size() - lb), 32'd2);
    rd(32'hC, d, er); chk("herr_status", d, 32'h4);
    ready_mode = 0; err_at = -1;
    repeat (2) @(negedge clk_i);
    chk("herr_no_words", 32'(got_dat.size() - gb), 32'd0);

    // Register access errors.
    wr(32'h10, 32'h5, 4'hF, er); chk("unmapped_wr_err", 32'(er), 32'd1);
    rd(32'h20, d, er);           chk("unmapped_rd_err", 32'(er), 32'd1);
    wr(32'hC, 32'h0, 4'hF, er);  chk("status_wr_err", 32'(er), 32'd1);
    rd(32'h8, d, er);            chk("ctrl_rd_err", 32'(er), 32'd0);

    // Writes while busy.
    set_range(32'h400, 32'h440);
    lb = host_log.size(); gb = got_dat.size();
    ready_mode = 2;
    wr(32'h8, 32'h1, 4'hF, er);
    repeat (10) @(negedge clk_i);
    rd(32'hC, d, er);  chk("busy_status", d, 32'h1);
    wr(32'h0, 32'h500, 4'hF, er); chk("busy_begin_err", 32'(er), 32'd1);
    rd(32'h0, d, er);  chk("busy_begin_kept", d, 32'h400);
    wr(32'h4, 32'h600, 4'hF, er); chk("busy_end_err", 32'(er), 32'd1);
    wr(32'h8, 32'h1, 4'hF, er);   chk("busy_start_ok", 32'(er), 32'd0);
    ready_mode = 0;
    wait_end(3000, "busy");
    check_stream(32'h400, 16, lb, gb, "busy");

    // Randomized ranges, latencies and backpressure.
    ready_mode = 1; rv_lat = -1;
    for (int k = 0; k < 6; k++) begin
      b  = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      nw = int'($urandom_range(1, 12));
      run_ok(b, nw, "rand");
    end
    ready_mode = 0;

    // Reset while a read is outstanding; the late response must be ignored.
    set_range(32'h600, 32'h610);
    rv_lat = 8;
    wr(32'h8, 32'h1, 4'hF, er);
    n = 0;
    while (!pend && n < 50) begin @(negedge clk_i); n++; end
    chk("rstw_pending", 32'(pend), 32'd1);
    @(posedge clk_i); #2 rst_i = 1'b1;
    #1;
    chk("rstw_host_req", 32'(bus.host_req_o), 32'd0);
    chk("rstw_host_addr", bus.host_addr_o, 32'd0);
    chk("rstw_valid", 32'(bus.sig_valid_o), 32'd0);
    chk("rstw_done", 32'(done_o), 32'd0);
    chk("rstw_err", 32'(err_o), 32'd0);
    chk("rstw_dev_rvalid", 32'(bus.dev_rvalid_o), 32'd0);
    vc = valid_cycles;
    @(posedge clk_i); #2 rst_i = 1'b0;
    n = 0;
    while (pend && n < 50) begin @(negedge clk_i); n++; end
    chk("rstw_late_rvalid_sent", 32'(pend), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("rstw_no_push", 32'(valid_cycles - vc), 32'd0);
    rd(32'hC, d, er); chk("rstw_status", d, 32'd0);
    rv_lat = -1;
    run_ok(32'h600, 4, "after_rst");

    chk("one_outstanding", 32'(outst_viol), 32'd0);
    chk("req_held", 32'(hold_viol), 32'd0);
    chk("data_stable", 32'(stab_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
